// File: rtl/window_variance.sv
// Window variance: folds four integral-image corners per stream into a window
// sum and sum-of-squares, then emits N*sum_sq - sum^2 for cascade normalisation.
module window_variance #(
  parameter int II_W          = 18,
  parameter int SII_W         = 26,
  parameter int FEATURE_WIDTH = 24,
  parameter int VAR_W         = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ii_valid,
  output logic               ii_ready,
  input  logic [II_W-1:0]    ii_data,
  input  logic [1:0]         ii_eot,
  input  logic               sii_valid,
  output logic               sii_ready,
  input  logic [SII_W-1:0]   sii_data,
  input  logic [1:0]         sii_eot,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [II_W-1:0]    dout_sum,
  output logic [VAR_W-1:0]   dout_var,
  output logic               dout_eot,
  output logic               err
);

  localparam int N = FEATURE_WIDTH * FEATURE_WIDTH;

  typedef enum logic [1:0] {ACCUM, MULT, SUB, OUT} state_t;

  state_t               state, state_next;
  logic [1:0]           idx;
  logic [II_W-1:0]      sum_acc;
  logic [SII_W-1:0]     sq_acc;
  logic                 frame_flag;
  logic [2*II_W-1:0]    sum_ext;
  logic [2*II_W-1:0]    sum_sq;
  logic [VAR_W-1:0]     n_sq;
  logic                 xfer;
  logic                 frame_err;
  logic                 window_done;

  assign xfer        = (state == ACCUM) & ii_valid & sii_valid;
  assign ii_ready    = rst & xfer;
  assign sii_ready   = rst & xfer;
  assign frame_err   = xfer & ((ii_eot != sii_eot) | (ii_eot[0] != (idx == 2'd3)));
  assign window_done = xfer & ~frame_err & (idx == 2'd3);
  assign sum_ext     = {{II_W{1'b0}}, sum_acc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (window_done) state_next = MULT;
      MULT:    state_next = SUB;
      SUB:     state_next = OUT;
      OUT:     if (dout_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Corner A loads, B and C subtract, D adds; wraparound cancels for valid windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= 2'd0;
      sum_acc    <= '0;
      sq_acc     <= '0;
      frame_flag <= 1'b0;
      err        <= 1'b0;
    end else if (frame_err) begin
      err     <= 1'b1;
      idx     <= 2'd0;
      sum_acc <= '0;
      sq_acc  <= '0;
    end else if (xfer) begin
      case (idx)
        2'd0: begin
          sum_acc <= ii_data;
          sq_acc  <= sii_data;
        end
        2'd1, 2'd2: begin
          sum_acc <= sum_acc - ii_data;
          sq_acc  <= sq_acc - sii_data;
        end
        default: begin
          sum_acc    <= sum_acc + ii_data;
          sq_acc     <= sq_acc + sii_data;
          frame_flag <= ii_eot[1];
        end
      endcase
      idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_sq     <= '0;
      n_sq       <= '0;
      dout_valid <= 1'b0;
      dout_sum   <= '0;
      dout_var   <= '0;
      dout_eot   <= 1'b0;
    end else begin
      if (state == MULT) begin
        sum_sq <= sum_ext * sum_ext;
        n_sq   <= VAR_W'(sq_acc) * VAR_W'(N);
      end
      if (state == SUB) begin
        dout_var   <= n_sq - VAR_W'(sum_sq);
        dout_sum   <= sum_acc;
        dout_eot   <= frame_flag;
        dout_valid <= 1'b1;
      end
      if (state == OUT && dout_ready) dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_variance.sv
// Self-checking bench for window_variance: a corner-level reference model is
// compared every cycle, and literal expectations pin the model's results.
`timescale 1ns/1ps
module tb_window_variance;

  localparam int II_W  = 18;
  localparam int SII_W = 26;
  localparam int VAR_W = 36;

  logic               clk;
  logic               rst;
  logic               ii_valid;
  logic               ii_ready;
  logic [II_W-1:0]    ii_data;
  logic [1:0]         ii_eot;
  logic               sii_valid;
  logic               sii_ready;
  logic [SII_W-1:0]   sii_data;
  logic [1:0]         sii_eot;
  logic               dout_valid;
  logic               dout_ready;
  logic [II_W-1:0]    dout_sum;
  logic [VAR_W-1:0]   dout_var;
  logic               dout_eot;
  logic               err;

  int checks = 0;
  int errors = 0;

  window_variance #(
    .II_W(II_W), .SII_W(SII_W), .FEATURE_WIDTH(24), .VAR_W(VAR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ii_valid(ii_valid), .ii_ready(ii_ready), .ii_data(ii_data), .ii_eot(ii_eot),
    .sii_valid(sii_valid), .sii_ready(sii_ready), .sii_data(sii_data), .sii_eot(sii_eot),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_sum(dout_sum),
    .dout_var(dout_var), .dout_eot(dout_eot), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare_val(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stores the four corners of a window and evaluates the
  // variance formula with plain integer arithmetic once corner D arrives.
  int      m_idx;
  int      m_delay;
  bit      m_busy, m_out, m_err, m_eot, m_acc;
  longint  c_ii[4];
  longint  c_sq[4];
  longint  m_sum, m_var, s, q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idx = 0; m_delay = 0; m_busy = 0; m_out = 0; m_err = 0;
      m_eot = 0; m_sum = 0; m_var = 0;
    end else begin
      m_acc = !m_busy && ii_valid && sii_valid;
      if (m_out && dout_ready) begin
        m_out  = 0;
        m_busy = 0;
      end
      if (m_delay > 0) begin
        m_delay--;
        if (m_delay == 0) m_out = 1;
      end
      if (m_acc) begin
        if (ii_eot != sii_eot || (ii_eot[0] != (m_idx == 3))) begin
          m_err = 1;
          m_idx = 0;
        end else begin
          c_ii[m_idx] = ii_data;
          c_sq[m_idx] = sii_data;
          if (m_idx == 3) begin
            s = c_ii[0] - c_ii[1] - c_ii[2] + c_ii[3];
            q = c_sq[0] - c_sq[1] - c_sq[2] + c_sq[3];
            m_sum   = s & ((64'd1 << II_W) - 1);
            m_var   = (576 * q - s * s) & ((64'd1 << VAR_W) - 1);
            m_eot   = ii_eot[1];
            m_busy  = 1;
            m_delay = 2;
            m_idx   = 0;
          end else begin
            m_idx++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    compare_val("ii_ready", ii_ready, rst && !m_busy && ii_valid && sii_valid);
    compare_val("sii_ready", sii_ready, rst && !m_busy && ii_valid && sii_valid);
    compare_val("dout_valid", dout_valid, m_out);
    compare_val("err", err, m_err);
    if (m_out) begin
      compare_val("dout_sum", dout_sum, m_sum);
      compare_val("dout_var", dout_var, m_var);
      compare_val("dout_eot", dout_eot, m_eot);
    end else if (!rst) begin
      compare_val("rst_sum", dout_sum, 0);
      compare_val("rst_var", dout_var, 0);
      compare_val("rst_eot", dout_eot, 0);
    end
  end

  // Presents one corner pair (entered and left on a falling edge).
  task automatic applyStimulus(input logic [II_W-1:0] ii, input logic [SII_W-1:0] sq,
                               input logic [1:0] ieot, input logic [1:0] seot,
                               input bit skew, output int waited);
    ii_data  = ii;  ii_eot  = ieot; ii_valid = 1'b1;
    sii_data = sq;  sii_eot = seot;
    if (skew) begin
      sii_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    sii_valid = 1'b1;
    waited = 0;
    #1;
    while (!ii_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL xfer_timeout: ready stayed low, required a transfer at %0t", $time);
    end
    @(negedge clk);
    ii_valid  = 1'b0;
    sii_valid = 1'b0;
  endtask

  task automatic send_window(input longint a, input longint b, input longint c, input longint d,
                             input longint qa, input longint qb, input longint qc, input longint qd,
                             input logic [1:0] eot_d, input bit skew, output int first_wait);
    int w;
    applyStimulus(II_W'(a), SII_W'(qa), 2'b00, 2'b00, skew, first_wait);
    applyStimulus(II_W'(b), SII_W'(qb), 2'b00, 2'b00, skew, w);
    applyStimulus(II_W'(c), SII_W'(qc), 2'b00, 2'b00, skew, w);
    applyStimulus(II_W'(d), SII_W'(qd), eot_d, eot_d, skew, w);
  endtask

  // Waits for the result, pins it against literals, optionally stalls, then handshakes.
  task automatic checkOutput(input longint exp_sum, input longint exp_var, input bit exp_eot,
                             input int hold);
    int cnt;
    cnt = 0;
    while (!dout_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    compare_val("latency", cnt, 2);
    compare_val("lit_sum", dout_sum, exp_sum);
    compare_val("lit_var", dout_var, exp_var);
    compare_val("lit_eot", dout_eot, exp_eot);
    if (hold > 0) begin
      ii_data = 18'h3ffff; sii_data = 26'h1; ii_eot = 2'b00; sii_eot = 2'b00;
      ii_valid = 1'b1; sii_valid = 1'b1;
      repeat (hold) @(negedge clk);
      #1;
      compare_val("held_sum", dout_sum, exp_sum);
      compare_val("held_var", dout_var, exp_var);
      compare_val("held_valid", dout_valid, 1);
    end
    ii_valid = 1'b0; sii_valid = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b0; ii_valid = 1'b0; sii_valid = 1'b0; dout_ready = 1'b0;
    ii_data = '0; sii_data = '0; ii_eot = 2'b00; sii_eot = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] uniform window");
    send_window(0, 0, 0, 5760, 0, 0, 0, 57600, 2'b01, 0, w);
    checkOutput(5760, 0, 0, 0);

    $display("[TB] non-uniform window");
    send_window(100, 200, 300, 1000, 1000, 2000, 3000, 40000, 2'b01, 0, w);
    checkOutput(600, 20376000, 0, 0);

    $display("[TB] join skew and output stall");
    send_window(100, 200, 300, 1000, 1000, 2000, 3000, 40000, 2'b01, 1, w);
    checkOutput(600, 20376000, 0, 5);

    $display("[TB] frame end, back-to-back windows");
    send_window(0, 0, 0, 5760, 0, 0, 0, 57600, 2'b01, 0, w);
    checkOutput(5760, 0, 0, 0);
    send_window(100, 200, 300, 1000, 1000, 2000, 3000, 40000, 2'b11, 0, w);
    compare_val("b2b_accept_wait", w, 0);
    checkOutput(600, 20376000, 1, 0);

    $display("[TB] framing error: early eot");
    applyStimulus(18'd100, 26'd1000, 2'b00, 2'b00, 0, w);
    applyStimulus(18'd200, 26'd2000, 2'b00, 2'b00, 0, w);
    applyStimulus(18'd300, 26'd3000, 2'b01, 2'b01, 0, w);
    repeat (4) @(negedge clk);
    #1;
    compare_val("err_early_eot", err, 1);
    compare_val("no_out_early_eot", dout_valid, 0);
    @(negedge clk);
    send_window(100, 200, 300, 1000, 1000, 2000, 3000, 40000, 2'b01, 0, w);
    checkOutput(600, 20376000, 0, 0);
    #1;
    compare_val("err_sticky", err, 1);
    @(negedge clk);

    $display("[TB] framing error: eot mismatch");
    applyStimulus(18'd100, 26'd1000, 2'b00, 2'b00, 0, w);
    applyStimulus(18'd200, 26'd2000, 2'b00, 2'b00, 0, w);
    applyStimulus(18'd300, 26'd3000, 2'b00, 2'b00, 0, w);
    applyStimulus(18'd1000, 26'd40000, 2'b01, 2'b00, 0, w);
    repeat (4) @(negedge clk);
    #1;
    compare_val("no_out_mismatch", dout_valid, 0);
    compare_val("err_mismatch", err, 1);
    @(negedge clk);

    $display("[TB] reset during MULT");
    send_window(0, 0, 0, 5760, 0, 0, 0, 57600, 2'b01, 0, w);
    rst = 1'b0;
    #1;
    compare_val("rst_mult_err", err, 0);
    compare_val("rst_mult_valid", dout_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] reset during OUT");
    send_window(100, 200, 300, 1000, 1000, 2000, 3000, 40000, 2'b01, 0, w);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    compare_val("rst_out_valid", dout_valid, 0);
    compare_val("rst_out_sum", dout_sum, 0);
    compare_val("rst_out_var", dout_var, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_window(100, 200, 300, 1000, 1000, 2000, 3000, 40000, 2'b01, 0, w);
    checkOutput(600, 20376000, 0, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
